alu_operand_sequencer: RTL and testbench

- Upstream stage of the 2-bit ALU pack block; sole source of its a, b, cin and select inputs.
- Collects operands from board switches one field per debounced pushbutton press, then holds a stable operand set for the ALU.
- Issues a one-cycle op_valid strobe so downstream logic can capture the ALU out value.
- Counts executed operations for on-board display.

---
 rtl/alu_operand_sequencer.sv | 119 +++++++++++
 tb/tb_alu_operand_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - debounced pushbutton operand loader feeding the 2-bit ALU pack
module alu_operand_sequencer #(
    parameter int DB_COUNT = 50000,
    parameter int DB_WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic [1:0] sw,
    output logic [1:0] a,
    output logic [1:0] b,
    output logic       cin,
    output logic [1:0] select,
    output logic       op_valid,
    output logic [2:0] state_led,
    output logic [7:0] exec_count
);

    typedef enum logic [2:0] {
        LOAD_A   = 3'd0,
        LOAD_B   = 3'd1,
        LOAD_CIN = 3'd2,
        LOAD_SEL = 3'd3,
        EXEC     = 3'd4
    } state_t;

    localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DB_COUNT - 1);

    logic [2:0]          state;
    logic                btn_meta;
    logic                btn_sync;
    logic [1:0]          sync_fill;
    logic [DB_WIDTH-1:0] db_cnt;
    logic                btn_stable;
    logic                btn_stable_d;
    logic                armed;
    logic                press;

    assign state_led = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta  <= 1'b0;
            btn_sync  <= 1'b0;
            sync_fill <= 2'b00;
        end else begin
            btn_meta  <= btn_next;
            btn_sync  <= btn_meta;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt     <= '0;
            btn_stable <= 1'b0;
        end else if (btn_sync == btn_stable) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            btn_stable <= btn_sync;
            db_cnt     <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // A button held through reset must be seen released before it may press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_stable_d <= 1'b0;
            armed        <= 1'b0;
            press        <= 1'b0;
        end else begin
            btn_stable_d <= btn_stable;
            if (sync_fill[1] && !btn_sync && !btn_stable)
                armed <= 1'b1;
            press <= armed & btn_stable & ~btn_stable_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LOAD_A;
            a          <= 2'b00;
            b          <= 2'b00;
            cin        <= 1'b0;
            select     <= 2'b00;
            op_valid   <= 1'b0;
            exec_count <= 8'd0;
        end else begin
            op_valid <= 1'b0;
            case (state)
                LOAD_A: if (press) begin
                    a     <= sw;
                    state <= LOAD_B;
                end
                LOAD_B: if (press) begin
                    b     <= sw;
                    state <= LOAD_CIN;
                end
                LOAD_CIN: if (press) begin
                    cin   <= sw[0];
                    state <= LOAD_SEL;
                end
                LOAD_SEL: if (press) begin
                    select     <= sw;
                    state      <= EXEC;
                    op_valid   <= 1'b1;
                    exec_count <= exec_count + 8'd1;
                end
                EXEC: if (press) begin
                    state <= LOAD_A;
                end
                default: state <= LOAD_A;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb/tb_alu_operand_sequencer.sv - self-checking bench for alu_operand_sequencer
module tb_alu_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_next;
    logic [1:0] sw;
    logic [1:0] a;
    logic [1:0] b;
    logic       cin;
    logic [1:0] select;
    logic       op_valid;
    logic [2:0] state_led;
    logic [7:0] exec_count;

    alu_operand_sequencer #(.DB_COUNT(4), .DB_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_next   (btn_next),
        .sw         (sw),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .select     (select),
        .op_valid   (op_valid),
        .state_led  (state_led),
        .exec_count (exec_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int   ov_total     = 0;
    int   ov_bad_state = 0;
    int   ov_consec    = 0;
    logic ov_prev      = 1'b0;

    always @(negedge clk) begin
        if (op_valid === 1'b1) begin
            ov_total++;
            if (state_led !== 3'd4) ov_bad_state++;
            if (ov_prev) ov_consec++;
        end
        ov_prev <= (op_valid === 1'b1);
    end

    typedef struct {
        logic [1:0] sa, sb, sc, ss;
        logic [1:0] ea, eb;
        logic       ec;
        logic [1:0] es;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_btn(input logic [1:0] v);
        sw       = v;
        btn_next = 1'b1;
        wait_cyc(10);
        btn_next = 1'b0;
        wait_cyc(10);
    endtask

    function automatic logic [31:0] all_outs();
        return {13'd0, a, b, cin, select, state_led, op_valid, exec_count};
    endfunction

    initial begin
        int         ov0;
        logic [1:0] sweep[8];

        vecs[0] = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd2, 2'd1, 1'b1, 2'd2};
        vecs[1] = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd3, 2'd3, 1'b0, 2'd1};
        vecs[2] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd2, 1'b1, 2'd3};
        vecs[3] = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd1, 2'd2, 1'b0, 2'd0};
        sweep   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3, 2'd1};

        rst      = 1'b1;
        btn_next = 1'b0;
        sw       = 2'b00;
        wait_cyc(3);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            wait_cyc(1);
            check("idle_after_reset", all_outs(), 32'd0);
        end

        for (int i = 0; i < 4; i++) begin
            ov0 = ov_total;
            press_btn(vecs[i].sa);
            press_btn(vecs[i].sb);
            press_btn(vecs[i].sc);
            press_btn(vecs[i].ss);
            check("vec_state_exec", state_led, 3'd4);
            check("vec_a", a, vecs[i].ea);
            check("vec_b", b, vecs[i].eb);
            check("vec_cin", cin, vecs[i].ec);
            check("vec_select", select, vecs[i].es);
            check("vec_op_valid_count", ov_total - ov0, 1);
            check("vec_exec_count", exec_count, i + 1);
            press_btn(2'd3);
            check("vec_back_to_load_a", state_led, 3'd0);
            check("vec_a_not_cleared", a, vecs[i].ea);
        end

        for (int k = 1; k <= 3; k++) begin
            sw       = 2'd3;
            btn_next = 1'b1;
            wait_cyc(k);
            btn_next = 1'b0;
            wait_cyc(12);
            check("glitch_state", state_led, 3'd0);
            check("glitch_a", a, 2'd1);
        end

        sw       = 2'd2;
        btn_next = 1'b1;
        wait_cyc(6);
        btn_next = 1'b0;
        wait_cyc(1);
        check("latency_not_early", state_led, 3'd0);
        wait_cyc(1);
        check("latency_capture", state_led, 3'd1);
        check("latency_a", a, 2'd2);
        wait_cyc(12);
        check("single_press", state_led, 3'd1);

        for (int i = 0; i < 16; i++) begin
            sw = i[1:0];
            wait_cyc(1);
            check("sweep_b_hold", b, 2'd2);
        end
        btn_next = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sw = sweep[i];
            if (i == 6) btn_next = 1'b0;
            wait_cyc(1);
        end
        sw = 2'd0;
        check("sweep_state", state_led, 3'd2);
        check("sweep_capture", b, 2'd1);
        wait_cyc(12);
        check("sweep_b_after", b, 2'd1);

        sw       = 2'd1;
        btn_next = 1'b1;
        wait_cyc(4);
        rst = 1'b1;
        #1;
        check("async_reset_clear", all_outs(), 32'd0);
        wait_cyc(3);
        check("reset_held", all_outs(), 32'd0);
        rst = 1'b0;
        wait_cyc(20);
        check("no_press_after_reset", all_outs(), 32'd0);
        btn_next = 1'b0;
        wait_cyc(12);
        press_btn(2'd3);
        check("fresh_press_state", state_led, 3'd1);
        check("fresh_press_a", a, 2'd3);

        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(4);
        ov0 = ov_total;
        repeat (256) begin
            press_btn(2'd1);
            press_btn(2'd2);
            press_btn(2'd1);
            press_btn(2'd3);
            press_btn(2'd0);
        end
        check("wrap_exec_count", exec_count, 8'd0);
        check("wrap_op_valid_count", ov_total - ov0, 256);
        check("wrap_state", state_led, 3'd0);

        ov0 = ov_total;
        force dut.state = 3'd6;
        #1;
        release dut.state;
        wait_cyc(1);
        check("illegal_state_recover", state_led, 3'd0);
        check("illegal_no_strobe", op_valid, 1'b0);
        wait_cyc(2);
        check("illegal_no_strobe_count", ov_total - ov0, 0);
        check("illegal_no_capture", {a, b, cin, select}, {2'd1, 2'd2, 1'b1, 2'd3});
        check("illegal_exec_count", exec_count, 8'd0);

        check("op_valid_only_in_exec", ov_bad_state, 0);
        check("op_valid_never_consecutive", ov_consec, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
